// File: rtl/wb_sram_ctrl.sv
// Wishbone B3 slave front-end for a single-port synchronous SRAM with one-cycle read latency.
// Handles classic cycles and CTI/BTE bursts. Read bursts stream one beat per cycle because the
// next word is fetched speculatively. Out-of-window requests are errored and never reach the SRAM.
module wb_sram_ctrl #(
  parameter int unsigned  DATA_WIDTH  = 32,
  parameter int unsigned  ADDR_WIDTH  = 32,
  parameter int unsigned  MEM_WORDS   = 1024,
  parameter int unsigned  LOCAL_WIDTH = 16,
  localparam int unsigned SEL_WIDTH   = DATA_WIDTH / 8,
  localparam int unsigned AW          = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_sys_n,

  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic [SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,

  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [SEL_WIDTH-1:0]  sram_be,
  output logic [AW-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int unsigned WW = LOCAL_WIDTH - 2;

  localparam logic [2:0] CtiIncr = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWrAck,
    StErrAck
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   held_q, held_d;

  logic [WW-1:0]   word_idx;
  logic            in_range;
  logic            addr_match;
  logic            req;
  logic            rd_ack;
  logic            accept;
  logic            acc_err;
  logic            acc_wr;
  logic            acc_rd;
  logic            burst_cont;
  logic            rd_hold;

  logic [AW-1:0]   held_inc;
  logic [AW-1:0]   wrap_mask;
  logic [AW-1:0]   next_idx;
  logic            next_in_range;

  // Only the local window of the byte address is decoded.
  logic            unused_adr;
  assign unused_adr = ^{wb_adr_i[ADDR_WIDTH-1:LOCAL_WIDTH], wb_adr_i[1:0]};

  assign word_idx   = wb_adr_i[LOCAL_WIDTH-1:2];
  assign in_range   = 32'(word_idx) < MEM_WORDS;
  assign addr_match = word_idx == WW'(held_q);
  assign req        = wb_cyc_i & wb_stb_i;

  // A read beat is acked only if it targets the word whose data is arriving this cycle.
  assign rd_ack = (state_q == StRd) & req & ~wb_we_i & addr_match;

  // New requests are taken in IDLE, or in RD when the current beat does not hit the prefetch.
  // Gating with reset keeps any SRAM write from escaping while reset is held.
  assign accept  = rst_sys_n & req & ((state_q == StIdle) | ((state_q == StRd) & ~rd_ack));
  assign acc_err = accept & ~in_range;
  assign acc_wr  = accept & in_range & wb_we_i;
  assign acc_rd  = accept & in_range & ~wb_we_i;

  // Prefetch the next burst word; an unreachable prediction is dropped and the burst ends.
  assign burst_cont = rd_ack & (wb_cti_i == CtiIncr) & next_in_range;

  // Master wait state inside a read burst: keep refreshing the held word.
  assign rd_hold = (state_q == StRd) & wb_cyc_i & ~wb_stb_i;

  // Burst address prediction: linear increments, wrap modes keep the upper bits fixed.
  always_comb begin
    held_inc = held_q + AW'(1);
    case (wb_bte_i)
      2'b01:   wrap_mask = AW'(3);
      2'b10:   wrap_mask = AW'(7);
      2'b11:   wrap_mask = AW'(15);
      default: wrap_mask = '0;
    endcase
    if (wrap_mask == '0) begin
      next_idx = held_inc;
    end else begin
      next_idx = (held_q & ~wrap_mask) | (held_inc & wrap_mask);
    end
  end

  assign next_in_range = 32'(next_idx) < MEM_WORDS;

  // State register.
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Word index of the read in flight.
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      held_q <= '0;
    end else begin
      held_q <= held_d;
    end
  end

  // Next-state and held-index selection.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    if (acc_err) begin
      state_d = StErrAck;
    end else if (acc_wr) begin
      state_d = StWrAck;
    end else if (acc_rd) begin
      state_d = StRd;
      held_d  = AW'(word_idx);
    end else begin
      unique case (state_q)
        StRd: begin
          if (burst_cont) begin
            held_d = next_idx;
          end else if (rd_ack || !wb_cyc_i) begin
            state_d = StIdle;
          end
        end
        StWrAck, StErrAck: state_d = StIdle;
        default:           state_d = state_q;
      endcase
    end
  end

  // Bus terminations and SRAM command decode.
  always_comb begin
    sram_ce    = acc_wr | acc_rd | burst_cont | rd_hold;
    sram_we    = acc_wr;
    sram_be    = acc_wr ? wb_sel_i : '0;
    sram_wdata = wb_dat_i;
    if (burst_cont) begin
      sram_addr = next_idx;
    end else if (rd_hold) begin
      sram_addr = held_q;
    end else begin
      sram_addr = AW'(word_idx);
    end

    wb_ack_o = rd_ack | (state_q == StWrAck);
    wb_err_o = state_q == StErrAck;
    wb_rty_o = 1'b0;
    wb_dat_o = (state_q == StRd) ? sram_rdata : '0;
  end

endmodule
